// File: rtl/mole_game_sequencer_if.sv
// Game I/O bundle for the whack-a-mole sequencer.
// master: the sequencer (consumes tick/start/sw, drives the display side).
// slave : the surrounding environment (prescaler, switches, LEDs, BCD path).
interface mole_game_sequencer_if;
  logic        tick;
  logic        start;
  logic [15:0] sw;
  logic [15:0] led;
  logic [5:0]  score;
  logic [4:0]  time_left;
  logic [1:0]  state;
  logic        game_over;
  logic        buzzer;

  modport master (
    input  tick, start, sw,
    output led, score, time_left, state, game_over, buzzer
  );

  modport slave (
    output tick, start, sw,
    input  led, score, time_left, state, game_over, buzzer
  );
endinterface

// File: rtl/mole_game_sequencer.sv
// Whack-a-mole game controller: IDLE -> PLAY <-> HIT -> OVER.
// A 16-bit Fibonacci LFSR picks the lit mole; switch rising edges score hits.
// Optional build macro: MISS_PENALTY_EN (wrong-switch edges in PLAY cost a point).
module mole_game_sequencer #(
  parameter int          GAME_SECONDS  = 20,
  parameter int          TICKS_PER_SEC = 10,
  parameter int          MOLE_LIFE     = 8,
  parameter int          BUZZ_TICKS    = 5,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  mole_game_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [4:0] GAME_TIME = 5'(GAME_SECONDS);
  localparam logic [7:0] SUB_LAST  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] LIFE_LAST = 8'(MOLE_LIFE - 1);
  localparam logic [7:0] BUZZ_LAST = 8'(BUZZ_TICKS - 1);

  // Fibonacci LFSR step, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Mole index from the fresh LFSR value; never repeat the previous mole.
  function automatic logic [3:0] pick_idx(input logic [15:0] nxt, input logic [3:0] prev);
    logic [3:0] idx;
    idx = nxt[3:0];
    if (idx == prev) begin
      idx = idx + 4'd1;
    end else begin
      idx = nxt[3:0];
    end
    return idx;
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? 6'd63 : v + 6'd1;
  endfunction

`ifdef MISS_PENALTY_EN
  function automatic logic [5:0] sat_dec(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction
`endif

  // Registered state
  state_t      state_r;
  logic [15:0] led_r;
  logic [5:0]  score_r;
  logic [4:0]  time_r;
  logic        game_over_r;
  logic        buzzer_r;
  logic [15:0] lfsr_r;
  logic [15:0] sw_q_r;
  logic [7:0]  sub_cnt_r;
  logic [7:0]  life_cnt_r;
  logic [7:0]  buzz_cnt_r;
  logic [3:0]  prev_idx_r;

  // Next-state values
  state_t      state_s;
  logic [15:0] led_s;
  logic [5:0]  score_s;
  logic [4:0]  time_s;
  logic        game_over_s;
  logic        buzzer_s;
  logic [15:0] lfsr_s;
  logic [7:0]  sub_cnt_s;
  logic [7:0]  life_cnt_s;
  logic [7:0]  buzz_cnt_s;
  logic [3:0]  prev_idx_s;
  logic        spawn_s;
  logic        launch_s;

  // Event decode
  logic [15:0] rise_s;
  logic        hit_s;
  logic        sec_end_s;
  logic        life_end_s;
  logic        game_end_s;
  logic [15:0] spawn_lfsr_s;
  logic [3:0]  spawn_idx_s;
`ifdef MISS_PENALTY_EN
  logic        miss_s;
`endif

  assign rise_s       = bus.sw & ~sw_q_r;
  assign hit_s        = |(rise_s & led_r);
  assign sec_end_s    = bus.tick && (sub_cnt_r == SUB_LAST);
  assign life_end_s   = bus.tick && (life_cnt_r == LIFE_LAST);
  // The game ends on the tick that takes time_left from 1 to 0.
  assign game_end_s   = sec_end_s && (time_r == 5'd1);
  assign spawn_lfsr_s = lfsr_next(lfsr_r);
  assign spawn_idx_s  = pick_idx(spawn_lfsr_s, prev_idx_r);
`ifdef MISS_PENALTY_EN
  assign miss_s       = |(rise_s & ~led_r);
`endif

  // Next-state and output decode for the game FSM and its counters.
  always_comb begin
    state_s     = state_r;
    led_s       = led_r;
    score_s     = score_r;
    time_s      = time_r;
    game_over_s = game_over_r;
    buzzer_s    = buzzer_r;
    lfsr_s      = lfsr_r;
    sub_cnt_s   = sub_cnt_r;
    life_cnt_s  = life_cnt_r;
    buzz_cnt_s  = buzz_cnt_r;
    prev_idx_s  = prev_idx_r;
    spawn_s     = 1'b0;
    launch_s    = 1'b0;

    case (state_r)
      IDLE: begin
        led_s       = 16'h0000;
        game_over_s = 1'b0;
        if (bus.start) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end

      PLAY, HIT: begin
        // The countdown runs in both PLAY and HIT.
        if (bus.tick) begin
          if (sec_end_s) begin
            sub_cnt_s = 8'd0;
            time_s    = time_r - 5'd1;
          end else begin
            sub_cnt_s = sub_cnt_r + 8'd1;
          end
        end else begin
          sub_cnt_s = sub_cnt_r;
        end

        if (state_r == PLAY) begin
          // A hit wins over a same-cycle mole expiry.
          if (hit_s) begin
            score_s    = sat_inc(score_r);
            led_s      = 16'h0000;
            life_cnt_s = 8'd0;
            state_s    = HIT;
          end else begin
`ifdef MISS_PENALTY_EN
            if (miss_s) begin
              score_s = sat_dec(score_r);
            end else begin
              score_s = score_r;
            end
`endif
            if (bus.tick) begin
              if (life_end_s) begin
                spawn_s = 1'b1;
              end else begin
                life_cnt_s = life_cnt_r + 8'd1;
              end
            end else begin
              life_cnt_s = life_cnt_r;
            end
          end
        end else begin
          // HIT: the board stays dark until the next tick brings a new mole.
          if (bus.tick) begin
            spawn_s = 1'b1;
            state_s = PLAY;
          end else begin
            state_s = HIT;
          end
        end

        // Final second overrides any move; the score update above still stands.
        if (game_end_s) begin
          state_s     = OVER;
          led_s       = 16'h0000;
          game_over_s = 1'b1;
          buzzer_s    = 1'b1;
          buzz_cnt_s  = 8'd0;
          spawn_s     = 1'b0;
        end else begin
          game_over_s = 1'b0;
        end
      end

      OVER: begin
        led_s       = 16'h0000;
        game_over_s = 1'b1;
        if (bus.tick && buzzer_r) begin
          if (buzz_cnt_r == BUZZ_LAST) begin
            buzzer_s = 1'b0;
          end else begin
            buzz_cnt_s = buzz_cnt_r + 8'd1;
          end
        end else begin
          buzz_cnt_s = buzz_cnt_r;
        end
        if (bus.start) begin
          launch_s = 1'b1;
        end else begin
          launch_s = 1'b0;
        end
      end

      default: begin
        state_s     = IDLE;
        led_s       = 16'h0000;
        game_over_s = 1'b0;
        buzzer_s    = 1'b0;
      end
    endcase

    // New game from IDLE or OVER.
    if (launch_s) begin
      state_s     = PLAY;
      score_s     = 6'd0;
      time_s      = GAME_TIME;
      sub_cnt_s   = 8'd0;
      game_over_s = 1'b0;
      buzzer_s    = 1'b0;
      buzz_cnt_s  = 8'd0;
      spawn_s     = 1'b1;
    end else begin
      launch_s = 1'b0;
    end

    // Spawn: advance the LFSR and light the chosen mole.
    if (spawn_s) begin
      lfsr_s     = spawn_lfsr_s;
      prev_idx_s = spawn_idx_s;
      led_s      = 16'd1 << spawn_idx_s;
      life_cnt_s = 8'd0;
    end else begin
      lfsr_s = lfsr_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      led_r       <= 16'h0000;
      score_r     <= 6'd0;
      time_r      <= GAME_TIME;
      game_over_r <= 1'b0;
      buzzer_r    <= 1'b0;
      lfsr_r      <= LFSR_SEED;
      sw_q_r      <= 16'h0000;
      sub_cnt_r   <= 8'd0;
      life_cnt_r  <= 8'd0;
      buzz_cnt_r  <= 8'd0;
      prev_idx_r  <= 4'd0;
    end else begin
      state_r     <= state_s;
      led_r       <= led_s;
      score_r     <= score_s;
      time_r      <= time_s;
      game_over_r <= game_over_s;
      buzzer_r    <= buzzer_s;
      lfsr_r      <= lfsr_s;
      sw_q_r      <= bus.sw;
      sub_cnt_r   <= sub_cnt_s;
      life_cnt_r  <= life_cnt_s;
      buzz_cnt_r  <= buzz_cnt_s;
      prev_idx_r  <= prev_idx_s;
    end
  end

  assign bus.led       = led_r;
  assign bus.score     = score_r;
  assign bus.time_left = time_r;
  assign bus.state     = state_r;
  assign bus.game_over = game_over_r;
  assign bus.buzzer    = buzzer_r;

endmodule

// File: tb/tb_mole_game_sequencer.sv
// Self-checking bench for mole_game_sequencer: directed scenarios followed by
// randomized play, compared every cycle against a game-rule reference model.
module tb_mole_game_sequencer;

  localparam int GS  = 20;
  localparam int TPS = 10;
  localparam int ML  = 8;
  localparam int BT  = 5;

  logic clk = 1'b0;
  logic reset;
  mole_game_sequencer_if bus ();

  mole_game_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game phase, score, ticks played, current mole, mole age,
  // buzzer ticks remaining, LFSR and previous mole index.
  int          m_phase;
  int          m_score;
  int          m_ticks;
  int          m_mole;
  int          m_age;
  int          m_buzz;
  int          m_prev;
  logic [15:0] m_lfsr;
  logic [15:0] m_swq;
  logic [15:0] cur_sw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mole_mask(input int idx);
    logic [15:0] one;
    one = 16'd1;
    return (idx >= 0) ? (one << idx) : 16'h0000;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_score = 0; m_ticks = 0; m_mole = -1; m_age = 0;
    m_buzz = 0; m_prev = 0; m_lfsr = 16'hACE1; m_swq = 16'h0000;
  endtask

  task automatic m_spawn();
    int idx;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    idx = int'(m_lfsr[3:0]);
    if (idx == m_prev) idx = (idx + 1) % 16;
    m_prev = idx;
    m_mole = idx;
    m_age  = 0;
  endtask

  task automatic m_new_game();
    m_phase = 1; m_score = 0; m_ticks = 0; m_buzz = 0;
    m_spawn();
  endtask

  task automatic m_edge(input logic t, input logic s, input logic [15:0] w);
    logic [15:0] rise;
    bit hit, ends;
    if (reset) begin
      m_reset();
      return;
    end
    rise  = w & ~m_swq;
    m_swq = w;
    if (m_phase == 0) begin
      if (s) m_new_game();
    end else if (m_phase == 3) begin
      if (t && m_buzz > 0) m_buzz--;
      if (s) m_new_game();
    end else begin
      hit = (m_phase == 1) && ((rise & mole_mask(m_mole)) != 16'h0000);
      if (t) m_ticks++;
      ends = t && (m_ticks == GS * TPS);
      if (m_phase == 1) begin
        if (hit) begin
          m_score = (m_score < 63) ? m_score + 1 : 63;
          m_mole  = -1;
          m_phase = 2;
        end else begin
`ifdef MISS_PENALTY_EN
          if ((rise & ~mole_mask(m_mole)) != 16'h0000 && m_score > 0) m_score--;
`endif
          if (t && !ends) begin
            m_age++;
            if (m_age == ML) m_spawn();
          end
        end
      end else if (t && !ends) begin
        m_spawn();
        m_phase = 1;
      end
      if (ends) begin
        m_phase = 3;
        m_mole  = -1;
        m_buzz  = BT;
      end
    end
  endtask

  task automatic check_all();
    chk("state",     32'(bus.state),     32'(m_phase));
    chk("led",       32'(bus.led),       32'(mole_mask(m_mole)));
    chk("score",     32'(bus.score),     32'(m_score));
    chk("time_left", 32'(bus.time_left), 32'(GS - m_ticks / TPS));
    chk("game_over", 32'(bus.game_over), 32'(m_phase == 3));
    chk("buzzer",    32'(bus.buzzer),    32'(m_phase == 3 && m_buzz > 0));
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic t, input logic s, input logic [15:0] w);
    bus.tick  = t;
    bus.start = s;
    bus.sw    = w;
    @(posedge clk);
    m_edge(t, s, w);
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, cur_sw);
      step(1'b0, 1'b0, cur_sw);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    cur_sw = 16'h0000;
  endtask

  initial begin
    int over_ticks;
    int drop_at;
    reset = 1'b1;
    bus.tick = 1'b0; bus.start = 1'b0; bus.sw = 16'h0000;
    cur_sw = 16'h0000;
    m_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_led",   32'(bus.led),   32'd0);
    chk("rst_time",  32'(bus.time_left), 32'd20);
    chk("rst_score", 32'(bus.score), 32'd0);

    // First mole after start
    step(1'b0, 1'b1, cur_sw);
    chk("start_state", 32'(bus.state), 32'd1);
    chk("first_mole",  32'(bus.led),   32'h0008);

    // Hit mole 3, then the next tick spawns mole 7
    cur_sw = 16'h0008;
    step(1'b0, 1'b0, cur_sw);
    chk("hit_score", 32'(bus.score), 32'd1);
    chk("hit_state", 32'(bus.state), 32'd2);
    chk("hit_led",   32'(bus.led),   32'd0);
    cur_sw = 16'h0000;
    step(1'b0, 1'b0, cur_sw);
    step(1'b1, 1'b0, cur_sw);
    chk("respawn_led",   32'(bus.led),   32'h0080);
    chk("respawn_state", 32'(bus.state), 32'd1);

    // Mole expiry after MOLE_LIFE ticks; held sw[7] never scores
    do_reset();
    step(1'b0, 1'b1, cur_sw);
    cur_sw = 16'h0080;
    step(1'b0, 1'b0, cur_sw);
    ticks(ML - 1);
    chk("pre_move_led", 32'(bus.led), 32'h0008);
    ticks(1);
    chk("moved_led",   32'(bus.led),   32'h0080);
    chk("moved_score", 32'(bus.score), 32'd0);
    ticks(2);
    chk("held_score", 32'(bus.score), 32'd0);
    cur_sw = 16'h0000;

    // Full game without hits, then buzzer and restart
    do_reset();
    step(1'b0, 1'b1, cur_sw);
    over_ticks = 0;
    while (over_ticks < 250 && bus.state != 2'd3) begin
      ticks(1);
      over_ticks++;
    end
    chk("game_ticks", 32'(over_ticks), 32'd200);
    chk("over_state", 32'(bus.state), 32'd3);
    chk("over_go",    32'(bus.game_over), 32'd1);
    chk("over_time",  32'(bus.time_left), 32'd0);
    chk("over_buzz",  32'(bus.buzzer), 32'd1);
    drop_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cur_sw = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      ticks(1);
      if (drop_at == 0 && bus.buzzer == 1'b0) drop_at = i;
    end
    chk("buzz_len",   32'(drop_at), 32'(BT));
    chk("over_score", 32'(bus.score), 32'd0);
    cur_sw = 16'h0000;
    step(1'b0, 1'b0, cur_sw);
    step(1'b0, 1'b1, cur_sw);
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_time",  32'(bus.time_left), 32'd20);

    // Score 4 then reset mid-game; the mole sequence restarts
    do_reset();
    step(1'b0, 1'b1, cur_sw);
    for (int k = 0; k < 4; k++) begin
      cur_sw = mole_mask(m_mole);
      step(1'b0, 1'b0, cur_sw);
      cur_sw = 16'h0000;
      step(1'b0, 1'b0, cur_sw);
      step(1'b1, 1'b0, cur_sw);
    end
    chk("score4", 32'(bus.score), 32'd4);
    do_reset();
    chk("midrst_score", 32'(bus.score), 32'd0);
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_led",   32'(bus.led),   32'd0);
    step(1'b0, 1'b1, cur_sw);
    chk("repro_mole", 32'(bus.led), 32'h0008);

    // Wrong-switch edges with score 1 (mole 7 lit, sw[0] is wrong)
    cur_sw = 16'h0008;
    step(1'b0, 1'b0, cur_sw);
    cur_sw = 16'h0000;
    step(1'b0, 1'b0, cur_sw);
    step(1'b1, 1'b0, cur_sw);
    cur_sw = 16'h0001;
    step(1'b0, 1'b0, cur_sw);
`ifdef MISS_PENALTY_EN
    chk("miss1", 32'(bus.score), 32'd0);
`else
    chk("miss1", 32'(bus.score), 32'd1);
`endif
    cur_sw = 16'h0000;
    step(1'b0, 1'b0, cur_sw);
    cur_sw = 16'h0001;
    step(1'b0, 1'b0, cur_sw);
`ifdef MISS_PENALTY_EN
    chk("miss2", 32'(bus.score), 32'd0);
`else
    chk("miss2", 32'(bus.score), 32'd1);
`endif

    // Randomized play against the model
    for (int c = 0; c < 4000; c++) begin
      logic t, s;
      reset = ($urandom_range(0, 1499) == 0);
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) cur_sw = cur_sw ^ mole_mask(int'($urandom_range(0, 15)));
      if (m_mole >= 0 && $urandom_range(0, 9) == 0) cur_sw = cur_sw | mole_mask(m_mole);
      if ($urandom_range(0, 7) == 0) cur_sw = 16'h0000;
      step(t, s, cur_sw);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_game_sequencer.md
Name: mole_game_sequencer

Overview:
Central game controller for the whack-a-mole design. It sequences a game from idle through play to game-over, and schedules which LED mole is lit using a 16-bit LFSR. It detects switch hits, keeps the score and the countdown, and drives the game-over buzzer. It sits between the slow-tick prescaler and switch inputs on one side, and the LED bank and the binary-to-BCD display path on the other.

Parameters:
GAME_SECONDS, 20, game length in seconds; loaded into time_left (5 bits, max 31).
TICKS_PER_SEC, 10, tick pulses per game second.
MOLE_LIFE, 8, ticks a mole stays lit before it moves without a hit.
BUZZ_TICKS, 5, ticks buzzer stays high on entering OVER.
LFSR_SEED, 16'hACE1, LFSR reset/start value; must be nonzero.

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle enable pulse from prescaler at TICKS_PER_SEC Hz
start  in  1  start request, level-sampled
sw  in  16  whack switches
led  out  16  one-hot mole, or all zero
score  out  6  hit count to the BCD path
time_left  out  5  seconds remaining to the BCD path
state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3
game_over  out  1  high while in OVER
buzzer  out  1  game-end tone enable

Behaviour:
- One clock domain; all outputs registered. Reset is synchronous and active-high.
- Reset values: state=IDLE, led=0, score=0, time_left=GAME_SECONDS, game_over=0, buzzer=0, lfsr=LFSR_SEED, sw_q=0, sub-second counter=0, mole-life counter=0.
- Edge detect:
  - sw_q <= sw every cycle.
  - rise = sw & ~sw_q.
  - Only rising edges count; held switches never re-score.
- Spawn operation:
  - lfsr <= next(lfsr). Fibonacci LFSR, taps 16,14,13,11: fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - idx = next[3:0]. If idx equals the previous mole index, use idx+1 mod 16.
  - led <= 1<<idx. Mole-life counter cleared.
- IDLE:
  - led=0.
  - start=1 -> PLAY next cycle with a spawn in the same edge. score=0, time_left=GAME_SECONDS, counters cleared.
- PLAY:
  - On tick: sub-second counter increments. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements.
  - On tick: mole-life counter increments. At MOLE_LIFE-1 a spawn occurs (mole moves, no score change).
  - rise[idx] -> score+1 (saturates at 63), led<=0, go to HIT.
  - Rising edges on non-mole switches are ignored unless the optional feature is enabled.
- HIT:
  - led=0 until the next tick. On that tick: spawn, return to PLAY.
  - The countdown keeps running in HIT.
- Transition to OVER: time_left decrementing from 1 to 0 (from PLAY or HIT) -> OVER.
- OVER:
  - led=0, game_over=1.
  - buzzer=1 for BUZZ_TICKS ticks after entry, then 0.
  - sw ignored; score and time_left=0 are held for display.
  - start=1 -> PLAY, same as from IDLE.
- Simultaneous events:
  - Hit and mole expiry in the same cycle: the hit wins and scores.
  - Hit and final-second expiry in the same cycle: score is incremented, then OVER.
  - Multiple rising edges in one cycle: the mole bit is evaluated first; other bits follow the miss rule.
- Reset mid-game: immediate return to reset values; the LFSR reseeds, so the mole sequence is reproducible.
- start held high in PLAY, HIT, or OVER after restart has no further effect until OVER.

Optional Feature:
MISS_PENALTY_EN:
- Defined: in PLAY, any rising edge on a non-mole switch decrements score, saturating at 0. Applied once per cycle, regardless of how many wrong bits rise. A same-cycle hit takes precedence, giving net +1.
- Undefined: wrong-switch edges have no effect.

Test Plan:
1. Reset held 2 cycles -> led=0, score=0, time_left=20, state=0, game_over=0, buzzer=0.
2. start=1 for 1 cycle from IDLE -> next cycle state=1, led=16'h0008 (lfsr=16'h59C3).
3. In PLAY with led=16'h0008, raise sw[3] -> next cycle score=1, state=2, led=0. Next tick -> led=16'h0080 (lfsr=16'hB387), state=1.
4. Restart from reset, start, no switch activity for 8 ticks -> led moves 16'h0008 -> 16'h0080, score stays 0. Holding sw[7] high before the move and through it does not score.
5. Start, 200 ticks with no hits -> time_left reaches 0 at tick 200, state=3, game_over=1, led=0, buzzer high for exactly 5 ticks. sw edges leave score=0. A further start returns to state=1 with time_left=20.
6. Reset asserted mid-PLAY with score=4 -> all outputs return to reset values. Start again reproduces first mole 16'h0008. With MISS_PENALTY_EN, score=1 plus a sw[0] edge gives score=0, and a second wrong edge keeps score=0.
